// File: rtl/lib_cpu_pkg.sv
// Shared CPU types: the EXECUTE record handed from the ALU stage to memory/write-back.
package lib_cpu;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned MEM_AW = 6;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic              w_req;
        logic [7:0]        w_data;
        logic              ack;
        logic              w_rd;
        logic [XLEN-1:0]   x_rd;
        logic              mem_r_req;
        logic              mem_w_req;
        logic [MEM_AW-1:0] mem_addr;
        logic              intr_en;
        logic [XLEN-1:0]   intr_pc;
        logic [XLEN-1:0]   intr_vec;
    } execute_t;

endpackage

// File: rtl/mem_wb_stage_pkg.sv
// Write-back stage package: FSM states, data RAM geometry and the commit payload.
package lib_wb;

    import lib_cpu::*;

    localparam int unsigned RAM_DEPTH = 64;
    localparam int unsigned RAM_AW    = $clog2(RAM_DEPTH);
    localparam int unsigned RAM_DW    = XLEN;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } wb_state_e;

    // Fields of EXECUTE that matter at commit time (strobes and sr state).
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            w_req;
        logic [7:0]      w_data;
        logic            ack;
        logic            intr_en;
        logic [XLEN-1:0] intr_pc;
        logic [XLEN-1:0] intr_vec;
    } wb_commit_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// EXECUTE -> mem/wb handshake bundle.
interface mem_wb_stage_if #(
    parameter int unsigned RF_AW = 4
);
    import lib_cpu::*;

    logic             ex_valid;
    logic             ex_ready;
    execute_t         ex_ex;
    logic [RF_AW-1:0] ex_rd;

    modport master (output ex_valid, output ex_ex, output ex_rd, input ex_ready);
    modport slave  (input ex_valid, input ex_ex, input ex_rd, output ex_ready);

endinterface

// File: rtl/mem_wb_stage_data_ram.sv
// 64x32 single-port data RAM: synchronous write, one-cycle synchronous read, write-first.
module data_ram
    import lib_wb::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [RAM_AW-1:0] addr_i,
    input  logic [RAM_DW-1:0] wdata_i,
    output logic [RAM_DW-1:0] rdata_o
);

    logic [RAM_DW-1:0] mem_q [RAM_DEPTH];
    logic [RAM_DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
            rdata_q       <= wdata_i;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: loads and stores against the data RAM, register-file
// commit, UART/interrupt strobes and the architectural sr registers.
module mem_wb_stage
    import lib_cpu::*;
    import lib_wb::*;
#(
    parameter logic [31:0] PC_RESET = 32'd0,
    parameter int unsigned RF_AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    mem_wb_stage_if.slave    ex_if,
    output logic             rf_we,
    output logic [RF_AW-1:0] rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             tx_req,
    output logic [7:0]       tx_data,
    output logic             intr_ack,
    output logic [31:0]      sr_pc,
    output logic [31:0]      sr_intr_pc,
    output logic [31:0]      sr_intr_vec,
    output logic             sr_intr_en,
    output logic             retire
);

    wb_state_e        state_q;
    logic             ready_q;
    wb_commit_t       ld_cm_q;
    logic [RF_AW-1:0] ld_rd_q;

    logic             rf_we_q, tx_req_q, intr_ack_q, retire_q, sr_intr_en_q;
    logic [RF_AW-1:0] rf_waddr_q;
    logic [31:0]      rf_wdata_q, sr_pc_q, sr_intr_pc_q, sr_intr_vec_q;
    logic [7:0]       tx_data_q;

    wb_commit_t       ex_cm_c, cm_c;
    logic             accept_c, commit_c, load_c, cm_we_c, ram_we_c, ram_re_c;
    logic [RF_AW-1:0] cm_addr_c;
    logic [31:0]      cm_data_c, ram_rdata;

    always_comb begin
        ex_cm_c.pc       = ex_if.ex_ex.pc;
        ex_cm_c.w_req    = ex_if.ex_ex.w_req;
        ex_cm_c.w_data   = ex_if.ex_ex.w_data;
        ex_cm_c.ack      = ex_if.ex_ex.ack;
        ex_cm_c.intr_en  = ex_if.ex_ex.intr_en;
        ex_cm_c.intr_pc  = ex_if.ex_ex.intr_pc;
        ex_cm_c.intr_vec = ex_if.ex_ex.intr_vec;
    end

    // Write-back mux: a LOAD cycle commits the latched load, otherwise the accepted record.
    always_comb begin
        accept_c  = ex_if.ex_valid && (state_q == ST_IDLE);
        commit_c  = 1'b0;
        load_c    = 1'b0;
        ram_we_c  = 1'b0;
        ram_re_c  = 1'b0;
        cm_we_c   = 1'b0;
        cm_c      = ex_cm_c;
        cm_addr_c = ex_if.ex_rd;
        cm_data_c = ex_if.ex_ex.x_rd;
        if (state_q == ST_LOAD) begin
            commit_c  = 1'b1;
            cm_we_c   = 1'b1;
            cm_c      = ld_cm_q;
            cm_addr_c = ld_rd_q;
            cm_data_c = ram_rdata;
        end else if (accept_c) begin
            if (ex_if.ex_ex.mem_w_req) begin
                ram_we_c = !reset;
                commit_c = 1'b1;
            end else if (ex_if.ex_ex.mem_r_req) begin
                ram_re_c = 1'b1;
                load_c   = 1'b1;
            end else begin
                commit_c = 1'b1;
                cm_we_c  = ex_if.ex_ex.w_rd;
            end
        end
        cm_we_c = cm_we_c && (cm_addr_c != '0);
    end

    data_ram u_data_ram (
        .clk     (clk),
        .we_i    (ram_we_c),
        .re_i    (ram_re_c),
        .addr_i  (ex_if.ex_ex.mem_addr),
        .wdata_i (ex_if.ex_ex.x_rd),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ready_q       <= 1'b1;
            ld_cm_q       <= '0;
            ld_rd_q       <= '0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            tx_req_q      <= 1'b0;
            tx_data_q     <= '0;
            intr_ack_q    <= 1'b0;
            retire_q      <= 1'b0;
            sr_pc_q       <= PC_RESET;
            sr_intr_en_q  <= 1'b0;
            sr_intr_pc_q  <= '0;
            sr_intr_vec_q <= '0;
        end else begin
            rf_we_q    <= cm_we_c;
            tx_req_q   <= commit_c && cm_c.w_req;
            intr_ack_q <= commit_c && cm_c.ack;
            retire_q   <= commit_c;
            if (cm_we_c) begin
                rf_waddr_q <= cm_addr_c;
                rf_wdata_q <= cm_data_c;
            end
            if (commit_c) begin
                tx_data_q     <= cm_c.w_data;
                sr_pc_q       <= cm_c.pc;
                sr_intr_en_q  <= cm_c.intr_en;
                sr_intr_pc_q  <= cm_c.intr_pc;
                sr_intr_vec_q <= cm_c.intr_vec;
            end
            if (load_c) begin
                ld_cm_q <= ex_cm_c;
                ld_rd_q <= ex_if.ex_rd;
            end
            case (state_q)
                ST_IDLE: if (load_c) begin
                    state_q <= ST_LOAD;
                    ready_q <= 1'b0;
                end
                ST_LOAD: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ex_if.ex_ready = ready_q;
    assign rf_we          = rf_we_q;
    assign rf_waddr       = rf_waddr_q;
    assign rf_wdata       = rf_wdata_q;
    assign tx_req         = tx_req_q;
    assign tx_data        = tx_data_q;
    assign intr_ack       = intr_ack_q;
    assign retire         = retire_q;
    assign sr_pc          = sr_pc_q;
    assign sr_intr_en     = sr_intr_en_q;
    assign sr_intr_pc     = sr_intr_pc_q;
    assign sr_intr_vec    = sr_intr_vec_q;

endmodule
